dmem_responder: RTL and testbench

//  Responder end of the CPU data-memory interface. Accepts one load/store request at a time over a

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency,
// word-organised array with byte-enable stores.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;

  logic [31:0]         mem [DEPTH];

  logic [AW-1:0]       idx;
  logic                addr_err;
  logic                commit;
  logic                mem_we;

  assign idx      = lat_addr[AW+1:2];
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    (lat_addr[ADDR_W-1:2] >=
                     (ADDR_W-2)'(DEPTH));
  assign commit   = (state == WAIT) && (cnt == 4'd0);
  assign mem_we   = commit && lat_wr && !addr_err;

  // Array write on the commit edge; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && lat_be[i]) begin
        mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_rdata <= (!lat_wr && !addr_err) ?
                         mem[idx] : 32'd0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table on a LATENCY=2 build,
// random traffic against a word-array model on a LATENCY=0 build.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rv2, rr2, sv2, sr2, er2;
  logic [31:0] rd2;
  logic        rv0, rr0, sv0, sr0, er0;
  logic [31:0] rd0;

  dmem_responder #(
    .DEPTH(1024), .ADDR_W(32), .LATENCY(2)
  ) u_l2 (
    .clk(clk), .rst(rst),
    .req_valid(rv2), .req_ready(rr2),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(sv2), .rsp_ready(sr2),
    .rsp_rdata(rd2), .rsp_err(er2)
  );

  dmem_responder #(
    .DEPTH(16), .ADDR_W(32), .LATENCY(0)
  ) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(rv0), .req_ready(rr0),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(sv0), .rsp_ready(sr0),
    .rsp_rdata(rd0), .rsp_err(er0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  function automatic logic g_rdy(int d);
    return (d == 0) ? rr0 : rr2;
  endfunction
  function automatic logic g_val(int d);
    return (d == 0) ? sv0 : sv2;
  endfunction
  function automatic logic [31:0] g_rd(int d);
    return (d == 0) ? rd0 : rd2;
  endfunction
  function automatic logic g_err(int d);
    return (d == 0) ? er0 : er2;
  endfunction

  // Latency counts the accepting edge as edge 1, so a
  // LATENCY=L build shows rsp_valid after edge L+2.
  task automatic xact(input int d, input bit wr,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] be,
                      input int hold, input int exp_lat,
                      output logic [31:0] rd,
                      output logic er);
    int n;
    int lat;
    rd = 32'd0;
    er = 1'b0;
    @(negedge clk);
    req_wr = wr; req_addr = a;
    req_wdata = wd; req_be = be;
    if (d == 0) rv0 = 1'b1; else rv2 = 1'b1;
    n = 0;
    while (!g_rdy(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 1, 0);
      rv0 = 1'b0; rv2 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rv0 = 1'b0; rv2 = 1'b0;
    req_wr = ~wr;
    req_addr = $urandom;
    req_wdata = $urandom;
    req_be = 4'($urandom);
    lat = 1;
    while (!g_val(d) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (!g_val(d)) return;
    rd = g_rd(d);
    er = g_err(d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(g_val(d)), 1);
      chk("hold_rdata", g_rd(d), rd);
      chk("hold_err", 32'(g_err(d)), 32'(er));
      chk("hold_ready", 32'(g_rdy(d)), 0);
    end
    @(negedge clk);
    if (d == 0) sr0 = 1'b1; else sr2 = 1'b1;
    @(posedge clk);
    #1;
    sr0 = 1'b0; sr2 = 1'b0;
    chk("rsp_done_valid", 32'(g_val(d)), 0);
    chk("rsp_done_ready", 32'(g_rdy(d)), 1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] ref_m [16];

  function automatic bit m_err(logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 16);
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0)
      return 32'($urandom_range(0, 15) * 4 +
                 $urandom_range(1, 3));
    if (k == 1)
      return 32'(64 + $urandom_range(0, 1000) * 4);
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a, wd, exp;
    logic [3:0]  be;

    rv2 = 0; sr2 = 0; rv0 = 0; sr0 = 0;
    req_wr = 0; req_addr = 0;
    req_wdata = 0; req_be = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(rr2), 1);
    chk("rst_valid", 32'(sv2), 0);
    chk("rst_rdata", rd2, 0);
    chk("rst_err", 32'(er2), 0);
    chk("rst0_ready", 32'(rr0), 1);
    chk("rst0_valid", 32'(sv0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // rsp_ready while idle has no effect
    sr2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rspready_valid", 32'(sv2), 0);
      chk("idle_rspready_ready", 32'(rr2), 1);
    end
    sr2 = 1'b0;

    tbl.push_back('{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0});
    tbl.push_back('{0, 32'h10, 0, 0, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 32'h20, 32'h11223344, 4'hF, 0, 0});
    tbl.push_back('{1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 0});
    tbl.push_back('{0, 32'h20, 0, 0, 32'h11BB33DD, 0});
    tbl.push_back('{0, 32'h13, 0, 0, 0, 1});
    tbl.push_back('{1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0});
    tbl.push_back('{1, 32'h1000, 32'h12345678, 4'hF, 0, 1});
    tbl.push_back('{0, 32'h0, 0, 0, 32'hCAFEF00D, 0});
    tbl.push_back('{1, 32'h22, 32'h0, 4'hF, 0, 1});
    tbl.push_back('{0, 32'h20, 0, 0, 32'h11BB33DD, 0});
    tbl.push_back('{0, 32'h1004, 0, 0, 0, 1});
    tbl.push_back('{1, 32'h24, 32'h55555555, 4'hF, 0, 0});
    tbl.push_back('{1, 32'h24, 32'hFFFFFFFF, 4'h0, 0, 0});
    tbl.push_back('{0, 32'h24, 0, 0, 32'h55555555, 0});
    tbl.push_back('{1, 32'hFFC, 32'h0BADF00D, 4'hF, 0, 0});
    tbl.push_back('{0, 32'hFFC, 0, 0, 32'h0BADF00D, 0});

    foreach (tbl[i]) begin
      xact(2, tbl[i].wr, tbl[i].a, tbl[i].wd,
           tbl[i].be, 0, 4, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i),
          32'(er), 32'(tbl[i].er));
    end

    // Backpressure: response held for 5 cycles
    xact(2, 0, 32'h10, 0, 0, 5, 4, rd, er);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    chk("bp_err", 32'(er), 0);

    // Reset during WAIT drops the store
    xact(2, 1, 32'h40, 32'h11111111, 4'hF, 0, 4, rd, er);
    @(negedge clk);
    req_wr = 1; req_addr = 32'h40;
    req_wdata = 32'h12345678; req_be = 4'hF;
    rv2 = 1'b1;
    @(posedge clk);
    #1 rv2 = 1'b0;
    chk("rst_mid_accepted", 32'(rr2), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(sv2), 0);
    chk("rst_mid_ready", 32'(rr2), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(sv2), 0);
    end
    xact(2, 0, 32'h40, 0, 0, 0, 4, rd, er);
    chk("rst_mid_old", rd, 32'h11111111);
    chk("rst_mid_err", 32'(er), 0);

    // LATENCY=0 build: fill, then random store/load pairs
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      ref_m[w] = wd;
      xact(0, 1, 32'(w * 4), wd, 4'hF, 0, 2, rd, er);
      chk("fill_err", 32'(er), 0);
    end
    for (int p = 0; p < 12; p++) begin
      a = rand_addr();
      wd = $urandom;
      be = 4'($urandom);
      xact(0, 1, a, wd, be, $urandom_range(0, 2), 2,
           rd, er);
      chk($sformatf("rnd%0d_st_err", p),
          32'(er), 32'(m_err(a)));
      chk($sformatf("rnd%0d_st_rdata", p), rd, 0);
      if (!m_err(a)) begin
        for (int b = 0; b < 4; b++)
          if (be[b])
            ref_m[a / 4][b * 8 +: 8] = wd[b * 8 +: 8];
      end
      if ($urandom_range(0, 1) == 0) a = rand_addr();
      xact(0, 0, a, 0, 0, 0, 2, rd, er);
      exp = m_err(a) ? 32'd0 : ref_m[a / 4];
      chk($sformatf("rnd%0d_ld_err", p),
          32'(er), 32'(m_err(a)));
      chk($sformatf("rnd%0d_ld_rdata", p), rd, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
